// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, branch condition codes and branch FSM states.
package cpu_pkg;

   localparam int unsigned XLEN = 16;

   typedef enum logic [2:0] {
      OpBeq = 3'd0,
      OpBne = 3'd1,
      OpBlt = 3'd2,
      OpBge = 3'd3,
      OpBgt = 3'd4,
      OpBle = 3'd5
   } br_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StResolve,
      StFlush
   } br_state_e;

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluation from the comparator's eq/gt/lt flags.
module br_cond
   import cpu_pkg::*;
(
   input  logic [2:0] op,
   input  logic       eq,
   input  logic       gt,
   input  logic       lt,
   output logic       taken,
   output logic       illegal
);

   logic cond;
   logic op_bad;
   logic one_hot;

   always_comb begin
      cond   = 1'b0;
      op_bad = 1'b0;
      case (br_op_e'(op))
         OpBeq:   cond = eq;
         OpBne:   cond = ~eq;
         OpBlt:   cond = lt;
         OpBge:   cond = gt | eq;
         OpBgt:   cond = gt;
         OpBle:   cond = lt | eq;
         default: op_bad = 1'b1;
      endcase
   end

   // A sane comparator asserts exactly one flag.
   always_comb begin
      case ({eq, gt, lt})
         3'b100, 3'b010, 3'b001: one_hot = 1'b1;
         default:                one_hot = 1'b0;
      endcase
   end

   assign illegal = op_bad | ~one_hot;
   assign taken   = cond & ~illegal;

endmodule

// File: rtl/branch_unit.sv
// Branch resolve unit: accepts one branch, resolves it, redirects the fetch PC and
// holds flush for FLUSH_CYCLES after a taken branch.
module branch_unit
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      br_op,
   input  logic            eq,
   input  logic            gt,
   input  logic            lt,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_offset,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic            br_taken,
   output logic            flush,
   output logic            err
);

   br_state_e       state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [2:0]      op_q;
   logic            eq_q, gt_q, lt_q;
   logic [XLEN-1:0] target_q;
   logic [XLEN-1:0] pc_q;
   logic            accept;
   logic            cond_taken;
   logic            cond_illegal;
   logic            redirect;

   br_cond u_br_cond (
      .op      (op_q),
      .eq      (eq_q),
      .gt      (gt_q),
      .lt      (lt_q),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   assign accept   = br_valid & br_ready;
   // Reset aborts a resolving branch, so the pulses are masked with it.
   assign redirect = (state_q == StResolve) & cond_taken & ~rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) state_d = StResolve;
         end
         StResolve: begin
            if (cond_taken) begin
               state_d = StFlush;
               cnt_d   = 3'(FLUSH_CYCLES - 1);
            end else begin
               state_d = StIdle;
            end
         end
         StFlush: begin
            if (cnt_q == 3'd0) state_d = StIdle;
            else               cnt_d   = cnt_q - 3'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= 3'd0;
         op_q     <= 3'd0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         target_q <= '0;
         pc_q     <= RESET_PC;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_q     <= br_op;
            eq_q     <= eq;
            gt_q     <= gt;
            lt_q     <= lt;
            target_q <= br_pc + br_offset;
         end
         if (redirect)    pc_q <= target_q;
         else if (!stall) pc_q <= pc_q + 1'b1;
      end
   end

   assign br_ready = (state_q == StIdle);
   assign flush    = (state_q == StFlush);
   assign br_taken = redirect;
   assign err      = (state_q == StResolve) & cond_illegal & ~rst;
   assign pc       = pc_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a cycle model queues expected outputs per driven cycle.
module tb_branch_unit;

   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam int unsigned FC       = 2;

   logic        clk = 1'b0;
   logic        rst, br_valid, br_ready, eq, gt, lt, stall;
   logic [2:0]  br_op;
   logic [15:0] br_pc, br_offset, pc;
   logic        br_taken, flush, err;

   always #5 clk = ~clk;

   branch_unit #(
      .RESET_PC     (RESET_PC),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .br_valid  (br_valid),
      .br_ready  (br_ready),
      .br_op     (br_op),
      .eq        (eq),
      .gt        (gt),
      .lt        (lt),
      .br_pc     (br_pc),
      .br_offset (br_offset),
      .stall     (stall),
      .pc        (pc),
      .br_taken  (br_taken),
      .flush     (flush),
      .err       (err)
   );

   typedef struct packed {
      logic [15:0] pc;
      logic        rdy;
      logic        tk;
      logic        fl;
      logic        er;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: 0 idle, 1 resolve, 2 flush; m_rem counts flush cycles left.
   int          m_state = 0;
   int          m_rem   = 0;
   logic [15:0] m_pc    = RESET_PC;
   logic [15:0] m_tgt   = '0;
   logic [2:0]  m_op    = '0;
   logic        m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Returns {illegal, taken}.
   function automatic logic [1:0] ref_cond(input logic [2:0] op, input logic e, g, l);
      logic ill, t;
      int   n;
      n   = int'(e) + int'(g) + int'(l);
      ill = (op > 3'd5) || (n != 1);
      case (op)
         3'd0:    t = e;
         3'd1:    t = !e;
         3'd2:    t = l;
         3'd3:    t = g | e;
         3'd4:    t = g;
         3'd5:    t = l | e;
         default: t = 1'b0;
      endcase
      return {ill, t && !ill};
   endfunction

   task automatic step(input logic r, v, input logic [2:0] op, input logic e, g, l,
                       input logic [15:0] bpc, boff, input logic s, input string tag);
      exp_t       x;
      logic [1:0] c;
      @(negedge clk);
      rst = r; br_valid = v; br_op = op; eq = e; gt = g; lt = l;
      br_pc = bpc; br_offset = boff; stall = s;
      if (r) begin
         m_state = 0; m_rem = 0; m_pc = RESET_PC;
      end else begin
         c = ref_cond(m_op, m_eq, m_gt, m_lt);
         case (m_state)
            0: begin
               if (!s) m_pc = m_pc + 16'd1;
               if (v) begin
                  m_op = op; m_eq = e; m_gt = g; m_lt = l;
                  m_tgt = bpc + boff; m_state = 1;
               end
            end
            1: begin
               if (c[0]) begin
                  m_pc = m_tgt; m_state = 2; m_rem = FC;
               end else begin
                  if (!s) m_pc = m_pc + 16'd1;
                  m_state = 0;
               end
            end
            default: begin
               if (!s) m_pc = m_pc + 16'd1;
               m_rem--;
               if (m_rem == 0) m_state = 0;
            end
         endcase
      end
      c    = ref_cond(m_op, m_eq, m_gt, m_lt);
      x.pc  = m_pc;
      x.rdy = (m_state == 0);
      x.fl  = (m_state == 2);
      x.tk  = (m_state == 1) && c[0];
      x.er  = (m_state == 1) && c[1];
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check({tag, ":pc"}, 32'(pc), 32'(x.pc));
      check({tag, ":br_ready"}, 32'(br_ready), 32'(x.rdy));
      check({tag, ":br_taken"}, 32'(br_taken), 32'(x.tk));
      check({tag, ":flush"}, 32'(flush), 32'(x.fl));
      check({tag, ":err"}, 32'(err), 32'(x.er));
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, tag);
   endtask

   task automatic br(input logic [2:0] op, input logic e, g, l, input logic [15:0] bpc, boff,
                     input string tag);
      step(1'b0, 1'b1, op, e, g, l, bpc, boff, 1'b0, tag);
   endtask

   initial begin
      rst = 1'b1; br_valid = 1'b0; br_op = 3'd0; eq = 1'b0; gt = 1'b0; lt = 1'b0;
      br_pc = '0; br_offset = '0; stall = 1'b0;

      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "rst0");
      step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h5, 16'h5, 1'b1, "rst1");
      check("rst_pc", 32'(pc), 32'h0000);
      check("rst_ready", 32'(br_ready), 32'h1);
      idle(3, "run");
      check("run_pc", 32'(pc), 32'h0003);

      // BEQ taken: redirect to 0x0030, two flush cycles.
      br(3'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0020, "beq");
      check("beq_taken", 32'(br_taken), 32'h1);
      idle(1, "beq_redir");
      check("beq_pc", 32'(pc), 32'h0030);
      check("beq_flush", 32'(flush), 32'h1);
      idle(2, "beq_flush");
      check("beq_ready", 32'(br_ready), 32'h1);

      // BLE with gt, not taken; a request during RESOLVE is ignored.
      br(3'd5, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0004, "ble");
      step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, "ignored");
      check("ign_pc", 32'(pc), 32'h0034);
      check("ign_ready", 32'(br_ready), 32'h1);
      br(3'd1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0001, "bne");
      idle(1, "bne_res");

      // Target wraps modulo 2^16.
      br(3'd2, 1'b0, 1'b0, 1'b1, 16'hFFF0, 16'h0020, "blt");
      idle(1, "blt_redir");
      check("blt_pc", 32'(pc), 32'h0010);
      idle(2, "blt_flush");

      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, "stall");
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, "stall");
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, "stall");
      check("stall_pc", 32'(pc), 32'h0012);

      // Redirect beats stall; stall in FLUSH holds the PC.
      br(3'd3, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0011, "bge");
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, "bge_stall");
      check("bge_stall_pc", 32'(pc), 32'h0411);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, "flush_stall");
      idle(1, "bge_done");

      br(3'd0, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0008, "err_eqgt");
      check("err_eqgt", 32'(err), 32'h1);
      idle(1, "err_eqgt_done");
      check("err_once", 32'(err), 32'h0);
      br(3'd7, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0008, "err_op7");
      check("err_op7", 32'(err), 32'h1);
      idle(1, "err_op7_done");
      br(3'd0, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0008, "err_none");
      idle(1, "err_none_done");
      br(3'd6, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0008, "err_op6");
      idle(1, "err_op6_done");

      // Reset on the first FLUSH cycle.
      br(3'd0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, "rf");
      idle(1, "rf_redir");
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "rf_rst");
      check("rf_flush", 32'(flush), 32'h0);
      check("rf_pc", 32'(pc), 32'h0000);
      idle(2, "rf_run");

      // Reset in RESOLVE suppresses the redirect.
      br(3'd4, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, "rr");
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "rr_rst");
      check("rr_pc", 32'(pc), 32'h0000);

      br(3'd4, 1'b0, 1'b1, 1'b0, 16'hFFF0, 16'h000E, "wrap");
      idle(2, "wrap_run");
      check("wrap_ffff", 32'(pc), 32'hFFFF);
      idle(1, "wrap_zero");
      check("wrap_pc", 32'(pc), 32'h0000);

      for (int i = 0; i < 300; i++) begin
         logic [2:0] f;
         f = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              f[2], f[1], f[0], 16'($urandom), 16'($urandom),
              ($urandom_range(0, 3) == 0), "rand");
      end

      check("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
